// File: rtl/float_rounding_if.sv
// Signal bundle between the adder normalizer and the float_rounding stage.
// The normalizer drives through the master modport; the rounding stage uses the slave modport.
interface float_rounding_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic [MANT_W-1:0] normMant;
  logic [EXP_W-1:0]  currExp;
  logic              shiftRound;
  logic              sticky;
  logic [MANT_W-1:0] roundMant;
  logic [EXP_W-1:0]  roundExp;
  logic              valid;

  modport master (
    output normMant, currExp, shiftRound, sticky,
    input  roundMant, roundExp, valid
  );

  modport slave (
    input  normMant, currExp, shiftRound, sticky,
    output roundMant, roundExp, valid
  );
endinterface

// File: rtl/float_rounding.sv
// Rounding stage of the single-precision adder. The default build truncates; define
// FLOAT_ROUNDING_RNE_EN to get round-to-nearest-even.
module float_rounding #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  float_rounding_if.slave  rif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
  localparam logic [MANT_W-1:0] MANT_INF = {1'b1, {(MANT_W-1){1'b0}}};

  state_t            state;
  logic [MANT_W-1:0] c_mant;
  logic [EXP_W-1:0]  c_exp;
  logic              c_g;
  logic              c_s;
  logic [MANT_W-1:0] round_mant_q;
  logic [EXP_W-1:0]  round_exp_q;
  logic              valid_q;

  logic              inc;
  logic [MANT_W+EXP_W-1:0] result;
  logic              in_match;
  logic              pair_new;

  // Carry out of the incrementer bumps the exponent; a maximal exponent saturates
  // and always encodes infinity.
  function automatic logic [MANT_W+EXP_W-1:0] round_result(
    input logic [MANT_W-1:0] m,
    input logic [EXP_W-1:0]  e,
    input logic              up
  );
    logic [MANT_W:0]   sum;
    logic [MANT_W-1:0] rm;
    logic [EXP_W-1:0]  re;
    sum = {1'b0, m} + {{MANT_W{1'b0}}, up};
    if (m == '0) begin
      rm = '0;
      re = '0;
    end else if (sum[MANT_W]) begin
      rm = sum[MANT_W:1];
      re = (e == EXP_MAX) ? EXP_MAX : e + EXP_W'(1);
    end else begin
      rm = sum[MANT_W-1:0];
      re = e;
    end
    if (re == EXP_MAX) rm = MANT_INF;
    return {rm, re};
  endfunction

  always_comb begin
`ifdef FLOAT_ROUNDING_RNE_EN
    inc = c_g & (c_s | c_mant[0]);
`else
    inc = 1'b0;
`endif
    result = round_result(c_mant, c_exp, inc);
  end

  assign in_match = (rif.normMant == c_mant) && (rif.currExp == c_exp) &&
                    (rif.shiftRound == c_g) && (rif.sticky == c_s);

  // The rounded result fed back through the normalizer must not retrigger rounding.
  assign pair_new = !(((rif.normMant == c_mant) && (rif.currExp == c_exp)) ||
                      ((rif.normMant == round_mant_q) && (rif.currExp == round_exp_q)));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      c_mant       <= '0;
      c_exp        <= '0;
      c_g          <= 1'b0;
      c_s          <= 1'b0;
      round_mant_q <= '0;
      round_exp_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          c_mant  <= rif.normMant;
          c_exp   <= rif.currExp;
          c_g     <= rif.shiftRound;
          c_s     <= rif.sticky;
          valid_q <= 1'b0;
          state   <= ROUND;
        end
        ROUND: begin
          if (in_match) begin
            round_mant_q <= result[MANT_W+EXP_W-1:EXP_W];
            round_exp_q  <= result[EXP_W-1:0];
            valid_q      <= 1'b1;
            state        <= DONE;
          end else begin
            c_mant <= rif.normMant;
            c_exp  <= rif.currExp;
            c_g    <= rif.shiftRound;
            c_s    <= rif.sticky;
          end
        end
        DONE: begin
          if (pair_new) begin
            c_mant  <= rif.normMant;
            c_exp   <= rif.currExp;
            c_g     <= rif.shiftRound;
            c_s     <= rif.sticky;
            valid_q <= 1'b0;
            state   <= ROUND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rif.roundMant = round_mant_q;
  assign rif.roundExp  = round_exp_q;
  assign rif.valid     = valid_q;

endmodule

// File: tb/tb_float_rounding.sv
// Directed-vector bench for float_rounding: stimulus queues expected results, a monitor
// checks them on each rising valid along with latency, output hold and reset values.
module tb_float_rounding;

`ifdef FLOAT_ROUNDING_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic Clock;
  logic Reset;
  float_rounding_if #(.MANT_W(24), .EXP_W(8)) rif ();

  float_rounding #(.MANT_W(24), .EXP_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .rif   (rif)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  logic [31:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Edge bookkeeping: reset seen at the last edge, and edges since the inputs last changed.
  logic [33:0] in_prev = '0;
  logic        rst_q   = 1'b0;
  int          since   = 0;
  always @(posedge Clock) begin
    if (Reset) since <= 0;
    else if ({rif.normMant, rif.currExp, rif.shiftRound, rif.sticky} != in_prev) since <= 1;
    else if (since < 1000) since <= since + 1;
    in_prev <= {rif.normMant, rif.currExp, rif.shiftRound, rif.sticky};
    rst_q   <= Reset;
  end

  task automatic drive(input logic [23:0] m, input logic [7:0] e, input logic g, input logic s);
    @(posedge Clock);
    #2;
    rif.normMant   = m;
    rif.currExp    = e;
    rif.shiftRound = g;
    rif.sticky     = s;
  endtask

  task automatic push(input logic [23:0] m, input logic [7:0] e);
    exp_q.push_back({m, e});
  endtask

  task automatic rst_drive(input logic [23:0] m, input logic [7:0] e, input logic g, input logic s);
    @(posedge Clock);
    #2;
    Reset          = 1'b1;
    rif.normMant   = m;
    rif.currExp    = e;
    rif.shiftRound = g;
    rif.sticky     = s;
    @(posedge Clock);
    #2;
    Reset = 1'b0;
  endtask

  // Stimulus
  initial begin
    Reset          = 1'b1;
    rif.normMant   = '0;
    rif.currExp    = '0;
    rif.shiftRound = 1'b0;
    rif.sticky     = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b0;
    push(24'h000000, 8'd0);
    repeat (4) @(posedge Clock);

    // Tie with odd LSB, reached from DONE by a new input pair
    drive(24'hC00001, 8'd130, 1'b1, 1'b0);
    push(RNE ? 24'hC00002 : 24'hC00001, 8'd130);
    repeat (4) @(posedge Clock);

    rst_drive(24'hC00001, 8'd130, 1'b1, 1'b1);
    push(RNE ? 24'hC00002 : 24'hC00001, 8'd130);
    repeat (4) @(posedge Clock);

    rst_drive(24'hC00001, 8'd130, 1'b0, 1'b1);
    push(24'hC00001, 8'd130);
    repeat (4) @(posedge Clock);

    // Round/sticky change alone while DONE must be ignored
    drive(24'hC00001, 8'd130, 1'b1, 1'b1);
    repeat (4) @(posedge Clock);

    // Tie with even LSB
    drive(24'hC00000, 8'd130, 1'b1, 1'b0);
    push(24'hC00000, 8'd130);
    repeat (4) @(posedge Clock);

    // Inputs changing every cycle keep valid low until they settle
    for (int i = 1; i <= 5; i++) drive(24'h800000 + 24'(i), 8'd120, 1'b0, 1'b0);
    push(24'h800005, 8'd120);
    repeat (4) @(posedge Clock);

    // Carry out of the significand
    drive(24'hFFFFFF, 8'd100, 1'b1, 1'b1);
    push(RNE ? 24'h800000 : 24'hFFFFFF, RNE ? 8'd101 : 8'd100);
    repeat (4) @(posedge Clock);

    // Feed the result back: nothing may change
    drive(RNE ? 24'h800000 : 24'hFFFFFF, RNE ? 8'd101 : 8'd100, 1'b1, 1'b1);
    repeat (4) @(posedge Clock);

    // Carry into the maximal exponent gives infinity
    drive(24'hFFFFFF, 8'd254, 1'b1, 1'b1);
    push(RNE ? 24'h800000 : 24'hFFFFFF, RNE ? 8'd255 : 8'd254);
    repeat (4) @(posedge Clock);

    // Exponent already maximal forces infinity in either mode
    drive(24'h900000, 8'd255, 1'b0, 1'b0);
    push(24'h800000, 8'd255);
    repeat (4) @(posedge Clock);

    // Zero significand yields zero regardless of exponent and round bits
    drive(24'h000000, 8'd50, 1'b1, 1'b1);
    push(24'h000000, 8'd0);
    repeat (4) @(posedge Clock);

    // Reset from DONE, then the held inputs round again
    rst_drive(24'hC00000, 8'd130, 1'b1, 1'b0);
    push(24'hC00000, 8'd130);
    repeat (4) @(posedge Clock);

    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic        prev_valid;
    logic [31:0] prev_out;
    logic [31:0] got;
    logic [31:0] want;
    prev_valid = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge Clock);
      got = {rif.roundMant, rif.roundExp};
      if (rst_q) begin
        checks++;
        if (rif.valid !== 1'b0 || got !== 32'h0) begin
          errors++;
          $display("FAIL reset: got valid=%b mant=%h exp=%0d, want valid=0 mant=000000 exp=0",
                   rif.valid, rif.roundMant, rif.roundExp);
        end
      end else if (rif.valid === 1'b1 && !prev_valid) begin
        checks++;
        if (since != 2) begin
          errors++;
          $display("FAIL latency: valid rose %0d edges after input change, want 2", since);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got mant=%h exp=%0d with nothing expected",
                   rif.roundMant, rif.roundExp);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL result: got mant=%h exp=%0d, want mant=%h exp=%0d",
                     got[31:8], got[7:0], want[31:8], want[7:0]);
          end
        end
      end else if (rif.valid === 1'b1 && prev_valid) begin
        checks++;
        if (got !== prev_out) begin
          errors++;
          $display("FAIL hold: outputs changed to mant=%h exp=%0d while valid, want mant=%h exp=%0d",
                   got[31:8], got[7:0], prev_out[31:8], prev_out[7:0]);
        end
      end
      prev_valid = (rif.valid === 1'b1);
      prev_out   = got;
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_result: %0d expected results never appeared, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/float_rounding.md
# float_rounding

Clocked rounding stage of the single-precision floating-point adder. It takes the normalized 24-bit significand (hidden bit at bit 23), the current exponent, and the round and sticky bits produced by alignment and normalization. It produces the rounded significand and exponent and flags completion with `valid`. The adder feeds the rounded result back through its normalizer, so the block treats its own output re-presented on its inputs as stable.

## Interface
Parameters:
- `MANT_W`, default 24: significand width, hidden bit included.
- `EXP_W`, default 8: biased exponent width.

Ports:
- `Clock`  input  1: rising-edge clock.
- `Reset`  input  1: synchronous, active-high reset.
- `normMant`  input  MANT_W: normalized significand; bit MANT_W-1 is the hidden one.
- `currExp`  input  EXP_W: biased exponent of `normMant`.
- `shiftRound`  input  1: round (guard) bit, the first bit below the LSB.
- `sticky`  input  1: OR of all bits below the guard bit.
- `roundMant`  output  MANT_W: rounded significand, hidden bit included.
- `roundExp`  output  EXP_W: rounded exponent.
- `valid`  output  1: the `roundMant`/`roundExp` pair is final.

## Operation
Internal capture registers:
- `c_mant`, `c_exp`, `c_g`, `c_s`.

Round-up condition:
- With `FLOAT_ROUNDING_RNE_EN`: `inc = c_g & (c_s | c_mant[0])`, i.e. round to nearest, ties to even.
- `sum = {1'b0, c_mant} + inc`, computed MANT_W+1 bits wide with an internal incrementer.

Result rules, in priority order:
- If `c_mant == 0`: result is mant 0, exp 0.
- If `sum[MANT_W]` is set (carry out): mant = `sum >> 1`, which equals `{1'b1, 0...}`, and exp = `c_exp + 1`.
- Otherwise: mant = `sum[MANT_W-1:0]`, exp = `c_exp`.
- If the resulting exp equals `2^EXP_W - 1` (255), force mant to `{1'b1, 0...}`, which encodes infinity. An exponent increment never wraps.

State machine:
- IDLE: `valid` = 0. Every edge captures the inputs and moves to ROUND.
- ROUND: if the current `normMant`/`currExp`/`shiftRound`/`sticky` equal the captured values, register the result into the outputs and move to DONE. Otherwise recapture and stay in ROUND.
- DONE: `valid` = 1 and the outputs are held.
  - If `normMant`/`currExp` differ from both the captured pair and the current output pair, recapture, clear `valid`, and move to ROUND.
  - Otherwise stay in DONE. Changes to `shiftRound`/`sticky` alone are ignored here.

## Timing
- Reset (synchronous, takes priority):
  - `roundMant` = 0, `roundExp` = 0, `valid` = 0.
  - Capture registers cleared; state IDLE.
- Latency:
  - Inputs stable before edge k are captured at edge k.
  - Result and `valid` = 1 appear after edge k+1, a minimum of 2 edges from input change.
- `valid` falls on the edge that detects a new input and rises no earlier than the next edge.
- Outputs change only on the edge entering DONE. They never change while `valid` = 1.
- Inputs that change every cycle keep the block in ROUND with `valid` = 0 indefinitely.
- Reset asserted mid-operation: the next edge returns to IDLE with all outputs 0.

## Configuration
- `FLOAT_ROUNDING_RNE_EN` defined: round to nearest, ties to even, as specified above.
- `FLOAT_ROUNDING_RNE_EN` undefined: truncation (round toward zero).
  - `inc` is always 0 and `shiftRound`/`sticky` are ignored for the result.
  - They are still compared for stability in ROUND.
  - No carry or overflow can occur; the infinity force still applies when `c_exp` is 255.

## Test plan
- Reset, then idle inputs of 0: `valid` = 0 through the reset cycles; after 2 edges, `valid` = 1, `roundMant` = 0, `roundExp` = 0.
- Rounding of `normMant` = 0xC00001, `currExp` = 130, with `shiftRound`/`sticky` varied:
  - g=1, s=0 (RNE tie, odd LSB): 0xC00002, exp 130, `valid` after 2 edges.
  - Macro undefined: 0xC00001.
  - g=1, s=1: 0xC00002.
  - g=0, s=1: 0xC00001.
- Tie with even LSB: 0xC00000, g=1, s=0 → 0xC00000, exp 130.
- Carry out: 0xFFFFFF, exp 100, g=1, s=1 → 0x800000, exp 101. With exp 254 → 0x800000, exp 255 (infinity).
- Handshake while in DONE:
  - Drive new inputs: `valid` drops at the next edge and returns one edge later with the new result.
  - Re-present the current output pair on the inputs: `valid` stays 1 and the outputs are unchanged.
  - Assert `Reset` for one edge: all outputs return to 0.
